// File: rtl/shift_2_pkg.sv
// shift_2_pkg: shared divider constants (word width, fill-mode encoding)
package shift_2_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int LOGICAL    = 0;
    localparam int ARITHMETIC = 1;
endpackage

// File: rtl/shift_const_core.sv
// shift_const_core: combinational fixed-distance right shift with fill and remainder
module shift_const_core
    import shift_2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = 2,
    parameter int ARITH = LOGICAL
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic [SHIFT-1:0] rem
);
    logic fill;
    assign fill = (ARITH == ARITHMETIC) && data[WIDTH-1];
    assign q    = en ? {{SHIFT{fill}}, data[WIDTH-1:SHIFT]} : data;
    assign rem  = en ? data[SHIFT-1:0] : '0;
endmodule

// File: rtl/shift_2.sv
// shift_2: registered divide-by-4 stage of the power-of-two divider chain
module shift_2
    import shift_2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = 2,
    parameter int ARITH = LOGICAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic [SHIFT-1:0] rem
);
    if (SHIFT < 1 || SHIFT >= WIDTH) begin : g_bad_shift
        $fatal(1, "shift_2: SHIFT=%0d must satisfy 1 <= SHIFT < WIDTH=%0d", SHIFT, WIDTH);
    end
    if (ARITH != LOGICAL && ARITH != ARITHMETIC) begin : g_bad_arith
        $fatal(1, "shift_2: ARITH=%0d must be 0 or 1", ARITH);
    end
    logic [WIDTH-1:0] q_next;
    logic [SHIFT-1:0] rem_next;
    shift_const_core #(.WIDTH(WIDTH), .SHIFT(SHIFT), .ARITH(ARITH)) u_core (
        .data(data),
        .en  (en),
        .q   (q_next),
        .rem (rem_next)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            rem <= '0;
        end else begin
            q   <= q_next;
            rem <= rem_next;
        end
    end
endmodule

// File: tb/tb_shift_2.sv
// tb_shift_2: randomized self-checking bench for shift_2 against a division-based model
module tb_shift_2;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        en;
    logic [15:0] q1, q2, q2a, q8;
    logic [0:0]  rem1;
    logic [1:0]  rem2, rem2a;
    logic [7:0]  rem8;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_2 #(.WIDTH(16), .SHIFT(2), .ARITH(0)) dut2  (.clk(clk), .rst(rst), .data(data), .en(en), .q(q2),  .rem(rem2));
    shift_2 #(.WIDTH(16), .SHIFT(2), .ARITH(1)) dut2a (.clk(clk), .rst(rst), .data(data), .en(en), .q(q2a), .rem(rem2a));
    shift_2 #(.WIDTH(16), .SHIFT(1), .ARITH(0)) dut1  (.clk(clk), .rst(rst), .data(data), .en(en), .q(q1),  .rem(rem1));
    shift_2 #(.WIDTH(16), .SHIFT(8), .ARITH(0)) dut8  (.clk(clk), .rst(rst), .data(data), .en(en), .q(q8),  .rem(rem8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_rem(input logic [15:0] d, input logic e, input int s);
        return e ? 16'(int'(d) % (1 << s)) : 16'd0;
    endfunction

    // floor division: (v - r) is an exact multiple of 2^s, so the quotient is exact
    function automatic logic [15:0] m_q(input logic [15:0] d, input logic e, input int s, input bit a);
        int v;
        if (!e) return d;
        v = a ? int'($signed(d)) : int'(d);
        return 16'((v - int'(m_rem(d, e, s))) / (1 << s));
    endfunction

    task automatic step(input logic [15:0] d, input logic e, input logic r);
        @(negedge clk);
        data = d;
        en   = e;
        rst  = r;
        @(posedge clk);
        #1;
        check("q2",    32'(q2),    r ? 32'd0 : 32'(m_q(d, e, 2, 1'b0)));
        check("rem2",  32'(rem2),  r ? 32'd0 : 32'(m_rem(d, e, 2)));
        check("q2a",   32'(q2a),   r ? 32'd0 : 32'(m_q(d, e, 2, 1'b1)));
        check("rem2a", 32'(rem2a), r ? 32'd0 : 32'(m_rem(d, e, 2)));
        check("q1",    32'(q1),    r ? 32'd0 : 32'(m_q(d, e, 1, 1'b0)));
        check("rem1",  32'(rem1),  r ? 32'd0 : 32'(m_rem(d, e, 1)));
        check("q8",    32'(q8),    r ? 32'd0 : 32'(m_q(d, e, 8, 1'b0)));
        check("rem8",  32'(rem8),  r ? 32'd0 : 32'(m_rem(d, e, 8)));
    endtask

    initial begin
        logic [15:0] d;
        logic        e;
        logic [15:0] prev;
        rst  = 1'b1;
        data = '0;
        en   = 1'b0;
        step(16'hAAAA, 1'b1, 1'b1);
        step(16'hAAAA, 1'b1, 1'b1);
        check("rst_q", 32'(q2), 32'h0);
        check("rst_rem", 32'(rem2), 32'h0);
        step(16'hAAAA, 1'b1, 1'b0);
        check("rel_q", 32'(q2), 32'h2AAA);
        check("rel_rem", 32'(rem2), 32'h2);
        step(16'hF0F0, 1'b1, 1'b0);
        check("en_q", 32'(q2), 32'h3C3C);
        check("en_rem", 32'(rem2), 32'h0);
        check("ar_neg_q", 32'(q2a), 32'hFC3C);
        step(16'hF0F0, 1'b0, 1'b0);
        check("pass_q", 32'(q2), 32'hF0F0);
        check("pass_rem", 32'(rem2), 32'h0);
        step(16'h0F0F, 1'b0, 1'b0);
        check("pass2_q", 32'(q2), 32'h0F0F);
        step(16'h0F0F, 1'b1, 1'b0);
        check("reen_q", 32'(q2), 32'h03C3);
        check("reen_rem", 32'(rem2), 32'h3);
        for (int i = 0; i < 6; i++) begin
            step(16'h0F0F, i[0], 1'b0);
            check("tog_q", 32'(q2), i[0] ? 32'h03C3 : 32'h0F0F);
        end
        step(16'h7FFF, 1'b1, 1'b0);
        check("ar_pos_q", 32'(q2a), 32'h1FFF);
        check("ar_pos_rem", 32'(rem2a), 32'h3);
        prev = m_q(16'h7FFF, 1'b1, 2, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            d = 16'($urandom);
            e = 1'($urandom);
            if (i == 500) begin
                @(negedge clk);
                check("hold_q", 32'(q2), 32'(prev));
                step(d, e, 1'b1);
                check("mid_rst_q", 32'(q2), 32'h0);
            end else begin
                step(d, e, 1'b0);
            end
            prev = (i == 500) ? 16'h0 : m_q(d, e, 2, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
